// File: rtl/servo_sweep_ctrl_pkg.sv
// Shared definitions for the servo sweep controller: command encoding,
// per-channel FSM states and default angle-to-pulse-width scaling.
package servo_pkg;

    localparam logic [1:0] CMD_HOLD    = 2'd0;
    localparam logic [1:0] CMD_TO_MAX  = 2'd1;
    localparam logic [1:0] CMD_TO_MIN  = 2'd2;
    localparam logic [1:0] CMD_TO_PARK = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MOVE    = 2'd1,
        ST_ARRIVED = 2'd2
    } servo_state_e;

    localparam int DEF_SCALE  = 1111;
    localparam int DEF_OFFSET = 50000;

endpackage

// File: rtl/servo_sweep_ctrl_if.sv
// Bundle between the sequencing FSM (master) and the sweep controller (slave).
interface servo_sweep_ctrl_if #(
    parameter int N_CH = 2,
    parameter int PW_W = 21
);
    logic [N_CH-1:0]      enable;
    logic [2*N_CH-1:0]    cmd;
    logic                 done_period;
    logic [PW_W*N_CH-1:0] pulse_width;
    logic [N_CH-1:0]      done;
    logic [N_CH-1:0]      busy;

    modport master (
        output enable, cmd, done_period,
        input  pulse_width, done, busy
    );

    modport slave (
        input  enable, cmd, done_period,
        output pulse_width, done, busy
    );
endinterface

// File: rtl/servo_sweep_ctrl_ch.sv
// One servo channel: IDLE/MOVE/ARRIVED FSM, saturating angle stepper and
// combinational angle-to-pulse-width conversion.
module servo_sweep_ch
    import servo_pkg::*;
#(
    parameter int ANGLE_W    = 8,
    parameter int PW_W       = 21,
    parameter int STEP       = 10,
    parameter int ANGLE_MIN  = 0,
    parameter int ANGLE_MAX  = 90,
    parameter int ANGLE_PARK = 45,
    parameter int SCALE      = DEF_SCALE,
    parameter int OFFSET     = DEF_OFFSET
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            enable,
    input  logic [1:0]      cmd,
    input  logic            done_period,
    output logic [PW_W-1:0] pulse_width,
    output logic            done,
    output logic            busy
);

    localparam logic [ANGLE_W-1:0] MIN_A  = ANGLE_W'(ANGLE_MIN);
    localparam logic [ANGLE_W-1:0] MAX_A  = ANGLE_W'(ANGLE_MAX);
    localparam logic [ANGLE_W-1:0] PARK_A = ANGLE_W'(ANGLE_PARK);
    localparam logic [ANGLE_W:0]   STEP_X = (ANGLE_W+1)'(STEP);

    logic [ANGLE_W-1:0] angle_p0;
    logic [ANGLE_W-1:0] angle_nxt;
    logic [ANGLE_W-1:0] target;
    servo_state_e       state_p0;
    servo_state_e       state_nxt;

    // The extra bit holds the carry/borrow so a step can never wrap past a stop.
    function automatic logic [ANGLE_W-1:0] sat_step_up(input logic [ANGLE_W-1:0] a,
                                                       input logic [ANGLE_W-1:0] t);
        logic [ANGLE_W:0] sum;
        sum = {1'b0, a} + STEP_X;
        return (sum > {1'b0, t}) ? t : sum[ANGLE_W-1:0];
    endfunction

    function automatic logic [ANGLE_W-1:0] sat_step_down(input logic [ANGLE_W-1:0] a,
                                                         input logic [ANGLE_W-1:0] t);
        logic [ANGLE_W:0] diff;
        diff = {1'b0, a} - STEP_X;
        return (diff[ANGLE_W] || (diff[ANGLE_W-1:0] < t)) ? t : diff[ANGLE_W-1:0];
    endfunction

    always_comb begin
        target    = MIN_A;
        angle_nxt = angle_p0;
        state_nxt = state_p0;
        case (cmd)
            CMD_TO_MAX:  target = MAX_A;
            CMD_TO_PARK: target = PARK_A;
            default:     target = MIN_A;
        endcase

        if (!enable) begin
            angle_nxt = MIN_A;
            state_nxt = ST_IDLE;
        end else if (cmd == CMD_HOLD) begin
            state_nxt = ST_IDLE;
        end else begin
            // Only an already-moving channel steps; a fresh command first enters MOVE.
            if ((state_p0 == ST_MOVE) && done_period && (angle_p0 != target)) begin
                angle_nxt = (angle_p0 < target) ? sat_step_up(angle_p0, target)
                                                : sat_step_down(angle_p0, target);
            end
            state_nxt = (angle_nxt == target) ? ST_ARRIVED : ST_MOVE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            angle_p0 <= MIN_A;
            state_p0 <= ST_IDLE;
        end else begin
            angle_p0 <= angle_nxt;
            state_p0 <= state_nxt;
        end
    end

    assign done        = (state_p0 == ST_ARRIVED);
    assign busy        = (state_p0 == ST_MOVE);
    assign pulse_width = PW_W'(angle_p0) * PW_W'(SCALE) + PW_W'(OFFSET);

endmodule

// File: rtl/servo_sweep_ctrl.sv
// Multi-channel servo sweep controller: replicates one independent channel
// per servo and slices the shared bus.
module servo_sweep_ctrl
    import servo_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int ANGLE_W    = 8,
    parameter int PW_W       = 21,
    parameter int STEP       = 10,
    parameter int ANGLE_MIN  = 0,
    parameter int ANGLE_MAX  = 90,
    parameter int ANGLE_PARK = 45,
    parameter int SCALE      = DEF_SCALE,
    parameter int OFFSET     = DEF_OFFSET
) (
    input  logic               CLK,
    input  logic               RST,
    servo_sweep_ctrl_if.slave  bus
);

    if (N_CH < 1) begin : g_bad_nch
        $error("servo_sweep_ctrl: N_CH must be at least 1");
    end
    if ((ANGLE_MIN < 0) || (ANGLE_MIN >= ANGLE_MAX) || (ANGLE_MAX >= (1 << ANGLE_W))) begin : g_bad_range
        $error("servo_sweep_ctrl: angle range must satisfy 0 <= ANGLE_MIN < ANGLE_MAX < 2**ANGLE_W");
    end
    if ((ANGLE_PARK < ANGLE_MIN) || (ANGLE_PARK > ANGLE_MAX)) begin : g_bad_park
        $error("servo_sweep_ctrl: ANGLE_PARK outside the end stops");
    end
    if ((STEP < 1) || (STEP > (ANGLE_MAX - ANGLE_MIN))) begin : g_bad_step
        $error("servo_sweep_ctrl: STEP must be in 1..ANGLE_MAX-ANGLE_MIN");
    end
    if ((longint'(ANGLE_MAX) * longint'(SCALE) + longint'(OFFSET)) >= (longint'(1) << PW_W)) begin : g_bad_pw
        $error("servo_sweep_ctrl: PW_W too narrow for the largest pulse width");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        servo_sweep_ch #(
            .ANGLE_W   (ANGLE_W),
            .PW_W      (PW_W),
            .STEP      (STEP),
            .ANGLE_MIN (ANGLE_MIN),
            .ANGLE_MAX (ANGLE_MAX),
            .ANGLE_PARK(ANGLE_PARK),
            .SCALE     (SCALE),
            .OFFSET    (OFFSET)
        ) u_ch (
            .CLK        (CLK),
            .RST        (RST),
            .enable     (bus.enable[i]),
            .cmd        (bus.cmd[2*i +: 2]),
            .done_period(bus.done_period),
            .pulse_width(bus.pulse_width[PW_W*i +: PW_W]),
            .done       (bus.done[i]),
            .busy       (bus.busy[i])
        );
    end

endmodule

// File: doc/servo_sweep_ctrl.md
# servo_sweep_ctrl

Multi-channel servo sweep controller: each channel steps an angle register toward a commanded end stop (max, min or park) by a fixed step per PWM period tick. It converts the angle to a pulse-width count for the downstream PWM generator. This generation adds per-channel commands, saturating steps for any STEP/range ratio, a park position, a busy flag and a synchronous reset. It sits between the sequencing FSM (commands, enables) and one PWM generator per channel.

## Interface

Parameters:
- N_CH, 2: number of independent servo channels
- ANGLE_W, 8: angle register width
- PW_W, 21: pulse-width output width per channel
- STEP, 10: angle increment per tick (1..ANGLE_MAX-ANGLE_MIN)
- ANGLE_MIN, 0: lower end stop and home angle
- ANGLE_MAX, 90: upper end stop
- ANGLE_PARK, 45: park angle, ANGLE_MIN ≤ ANGLE_PARK ≤ ANGLE_MAX
- SCALE, 1111: counts per degree
- OFFSET, 50000: counts at 0°

Ports:
- CLK  in  1  single clock
- RST  in  1  synchronous, active-high reset
- enable  in  N_CH  per-channel enable; low forces channel home
- cmd  in  2·N_CH  per-channel command, channel i at [2i+1:2i]: 0 HOLD, 1 TO_MAX, 2 TO_MIN, 3 TO_PARK
- done_period  in  1  one-cycle tick, once per PWM period, shared by all channels
- pulse_width  out  PW_W·N_CH  channel i at [PW_W·(i+1)-1:PW_W·i]
- done  out  N_CH  commanded target reached
- busy  out  N_CH  channel moving toward a target not yet reached

## Operation

- Per channel FSM, states IDLE, MOVE, ARRIVED:
  - IDLE: cmd=HOLD, angle frozen.
  - MOVE: cmd≠HOLD and angle≠target.
  - ARRIVED: angle==target.
- Target: TO_MAX→ANGLE_MAX, TO_MIN→ANGLE_MIN, TO_PARK→ANGLE_PARK.
- In MOVE, on a cycle with done_period=1, angle moves one step toward target:
  - Up: min(angle+STEP, target). Down: max(angle−STEP, target).
  - Compute in ANGLE_W+1 bits. No overshoot, no wrap.
- pulse_width = angle·SCALE + OFFSET, zero-extended to PW_W. Pure function of the angle register.
- done=1 in ARRIVED. busy=1 in MOVE. Both are 0 in IDLE.
- Command change:
  - Leaving ARRIVED for a new target clears done on the next edge.
  - A reversal mid-sweep takes effect at the next tick; no partial step.
- cmd=HOLD while moving: angle frozen, done=0, busy=0. The FSM resumes when a target command returns.
- enable=0: angle←ANGLE_MIN, done←0, busy←0 on the next edge, regardless of cmd or tick.
- Channels are fully independent and share only done_period.

## Timing

- Reset values: angle=ANGLE_MIN for all channels, so every pulse_width=ANGLE_MIN·SCALE+OFFSET (50000 at defaults); done=0, busy=0, state IDLE.
- RST has priority over enable. enable has priority over cmd and done_period.
- A tick with RST or enable low is lost; no queued step.
- Angle update latency: the rising edge sampling done_period=1. pulse_width reflects the new angle in that same cycle, with no extra register stage.
- State, done and busy are registered from the next-state angle:
  - done rises on the same edge that writes angle=target.
  - busy falls on that edge.
  - busy rises one edge after a target command appears with angle≠target.
- Command already at target when issued: done=1 one edge later, with no tick required.
- Ticks are counted only as done_period samples. A multi-cycle high done_period counts once per cycle; the upstream block guarantees single-cycle ticks.
- Reset mid-sweep: the next edge returns to reset values. The sweep restarts only on a new tick after RST falls.

## Structure

- Package servo_pkg holds:
  - the cmd encoding constants (CMD_HOLD, CMD_TO_MAX, CMD_TO_MIN, CMD_TO_PARK);
  - the FSM state encoding;
  - default SCALE/OFFSET.
- Sub-module servo_sweep_ch: one channel (FSM, angle register, saturating step, pulse-width multiply), generated N_CH times.
- Top-level servo_sweep_ctrl does only generate/slicing. Parameter legality checks go in elaboration-time assertions there.

## Test plan

- Reset: assert RST 2 cycles with enable=all ones → every pulse_width=50000, done=0, busy=0.
- Non-divisible step (STEP=7, ch0 TO_MAX, 14 ticks): angle sequence 0,7,…,84,90 → final pulse_width=149990; done rises on the edge writing 90; further ticks leave angle at 90.
- Reversal: ch0 TO_MAX with STEP=10 reaches 40, then cmd=TO_MIN → next tick gives 30; after 3 more ticks angle=0 and done=1.
- Park and independence: ch0 TO_PARK and ch1 TO_MAX at the same time, STEP=10 → ch0 saturates at 45 after 5 ticks (pulse_width 99995) while ch1 is still busy at 50; ch1 reaches 90 after 9 ticks.
- Enable drop mid-sweep: ch1 at 60 with busy=1, enable[1]=0 for 1 cycle → angle=0 and done=busy=0 on the next edge; ch0 unaffected.
- Reset mid-sweep with a tick in the same cycle → no step applied; reset values are present next cycle.
